asym_sdp_bram18k_core: RTL and testbench
========================================

// Module: asym_sdp_bram18k_core
// PURPOSE
//  Single-clock, synthesizable, asymmetric simple-dual-port 18 Kbit RAM.
//  - Write port and read port each configurable as 9-bit (2048 deep) or 18-bit (1024 deep).
//  - Serves as the memory-side responder for the asymmetric BRAM SDP benches.
//  - Golden behavioural model against which the mapped qlf_k6n10f 18K BRAM is checked.
// PARAMETERS
//  WR_DATA_WIDTH  9   write port width; legal values 9 or 18
//  RD_DATA_WIDTH  18  read port width; legal values 9 or 18
//  WR_ADDR_WIDTH  derived localparam: 11 if WR_DATA_WIDTH==9, else 10
//  RD_ADDR_WIDTH  derived localparam: 11 if RD_DATA_WIDTH==9, else 10
// PORTS
//  clock0     in   1              single clock; all logic on posedge
//  RESET_i    in   1              asynchronous reset, active-high
//  WEN_i      in   1              write enable, sampled on posedge clock0
//  WR_ADDR_i  in   WR_ADDR_WIDTH  write address, in write-port word units
//  WDATA_i    in   WR_DATA_WIDTH  write data
//  REN_i      in   1              read enable, sampled on posedge clock0
//  RD_ADDR_i  in   RD_ADDR_WIDTH  read address, in read-port word units
//  RDATA_o    out  RD_DATA_WIDTH  registered read data
//  RVALID_o   out  1              RDATA_o updated this cycle
// BEHAVIOUR
//  Storage
//   - 2048 x 9-bit lanes.
//   - Each 9-bit lane is {p, d[7:0]}.
//   - 18-bit word N spans lane 2N (L0) and lane 2N+1 (L1).
//   - 18-bit layout: {L1.p, L0.p, L1.d[7:0], L0.d[7:0]}.
//  Write, 9-bit port: lane WR_ADDR_i <= WDATA_i.
//  Write, 18-bit port: both lanes of word WR_ADDR_i are written, unpacked per the layout.
//  Read, 9-bit port: lane RD_ADDR_i is returned.
//  Read, 18-bit port: word RD_ADDR_i is returned, packed per the layout.
//  Read latency: 1 cycle.
//   - REN_i=1 at edge k -> RDATA_o valid after edge k, RVALID_o=1 for exactly that cycle.
//   - REN_i=0 -> RDATA_o holds its last value; RVALID_o=0.
//  Collision: read and write in the same edge touching any common lane.
//   - Read-first: RDATA_o returns the pre-write contents.
//   - The write still completes.
//  Partial overlap (9-bit write into one lane of an 18-bit read) is read-first per lane.
//  Reset
//   - RDATA_o=0 and RVALID_o=0 immediately on RESET_i.
//   - Array contents are NOT cleared and are unknown (X) after power-up.
//   - A read in flight when RESET_i asserts is dropped; no RVALID_o after release.
//   - WEN_i/REN_i asserted while RESET_i=1 are ignored.
//  Address wrap: addresses are full-range; there is no out-of-range case and no wrap logic.
//  Illegal width parameters are caught by elaboration-time $error.
// STRUCTURE
//  Package qlf_bram_pkg
//   - LANE_W=9, LANES=2048.
//   - Width-to-address-width function.
//   - pack18(L1,L0) and unpack18(word) functions implementing the {p1,p0,d1,d0} layout.
//  Sub-module asym_bram_lane_mux
//   - Combinational lane select and pack/unpack between the port width and the 9-bit lane array.
//   - Instantiated once per port.
//  Top module holds the lane array, the write decode, the read register and RVALID_o.
// TESTING
//  1. 9w/18r: fill all 2048 lanes, lane a = a[9:1]; read words 0..1023.
//     -> word a = {a[8],a[8],a[7:0],a[7:0]}; zero mismatches.
//  2. 18w/9r: write word a = {a[8],a[8],a[7:0],a[7:0]} for a=0..1023; read lanes 0..2047.
//     -> lane a = a[9:1].
//  3. Latency: REN_i pulsed one cycle at addr 5.
//     -> RVALID_o=1 exactly one cycle later; RDATA_o then holds with REN_i=0.
//  4. Collision, 9w/18r: word 3 holds 18'h3FFFF; same edge write lane 6=9'h000 and read word 3.
//     -> RDATA_o=18'h3FFFF; next read of word 3 -> 18'h2FF00.
//  5. RESET_i asserted mid-read, between REN_i and data.
//     -> RDATA_o=0 and RVALID_o=0 immediately; no RVALID_o after release.
//     -> Previously written lanes still read back correctly.
//  6. 18w/18r and 9w/9r: random write/read pairs at 200 addresses -> readback equals written data.

Source files
------------

// File: rtl/qlf_bram_pkg.sv
// Shared geometry and lane pack/unpack helpers for the asymmetric 18K BRAM model.
package qlf_bram_pkg;

    localparam int unsigned LANE_W  = 9;
    localparam int unsigned LANES   = 2048;
    localparam int unsigned PAIRS   = LANES / 2;
    localparam int unsigned PAIR_AW = 10;

    // One 18-bit word viewed as its two 9-bit lanes {p, d[7:0]}
    typedef struct packed {
        logic [LANE_W-1:0] l1;
        logic [LANE_W-1:0] l0;
    } lane_pair_t;

    // Port data width to port address width (9-bit ports see twice as many words)
    function automatic int unsigned addr_width(input int unsigned data_width);
        return (data_width == 9) ? 11 : 10;
    endfunction

    // Parity bits sit on top, data bytes below: {p1, p0, d1, d0}
    function automatic logic [17:0] pack18(input logic [LANE_W-1:0] l1,
                                           input logic [LANE_W-1:0] l0);
        return {l1[8], l0[8], l1[7:0], l0[7:0]};
    endfunction

    function automatic lane_pair_t unpack18(input logic [17:0] word);
        lane_pair_t lp;
        lp.l1 = {word[17], word[15:8]};
        lp.l0 = {word[16], word[7:0]};
        return lp;
    endfunction

endpackage

// File: rtl/asym_bram_lane_mux.sv
// Maps one port (9- or 18-bit) onto a lane pair of the 9-bit lane array.
module asym_bram_lane_mux
    import qlf_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    localparam int unsigned ADDR_WIDTH = addr_width(DATA_WIDTH)
) (
    input  logic [ADDR_WIDTH-1:0] port_addr,
    input  logic [DATA_WIDTH-1:0] port_wdata,
    input  logic [LANE_W-1:0]     lane_rdata_even,
    input  logic [LANE_W-1:0]     lane_rdata_odd,
    output logic [PAIR_AW-1:0]    pair_addr,
    output logic [1:0]            lane_mask,
    output lane_pair_t            lane_wdata,
    output logic [DATA_WIDTH-1:0] port_rdata
);

    if (DATA_WIDTH == 9) begin : gen_narrow
        // Narrow port: low address bit selects the lane within the pair
        always_comb begin
            pair_addr  = port_addr[ADDR_WIDTH-1:1];
            lane_mask  = port_addr[0] ? 2'b10 : 2'b01;
            lane_wdata = '{l1: port_wdata, l0: port_wdata};
            port_rdata = port_addr[0] ? lane_rdata_odd : lane_rdata_even;
        end
    end else begin : gen_wide
        // Wide port: both lanes of the pair, repacked with parity bits on top
        always_comb begin
            pair_addr  = port_addr;
            lane_mask  = 2'b11;
            lane_wdata = unpack18(port_wdata);
            port_rdata = pack18(lane_rdata_odd, lane_rdata_even);
        end
    end

endmodule

// File: rtl/asym_sdp_bram18k_core.sv
// Asymmetric simple-dual-port 18 Kbit RAM: lane array, write decode, read register.
module asym_sdp_bram18k_core
    import qlf_bram_pkg::*;
#(
    parameter int unsigned WR_DATA_WIDTH = 9,
    parameter int unsigned RD_DATA_WIDTH = 18,
    localparam int unsigned WR_ADDR_WIDTH = addr_width(WR_DATA_WIDTH),
    localparam int unsigned RD_ADDR_WIDTH = addr_width(RD_DATA_WIDTH)
) (
    input  logic                     clock0,
    input  logic                     RESET_i,
    input  logic                     WEN_i,
    input  logic [WR_ADDR_WIDTH-1:0] WR_ADDR_i,
    input  logic [WR_DATA_WIDTH-1:0] WDATA_i,
    input  logic                     REN_i,
    input  logic [RD_ADDR_WIDTH-1:0] RD_ADDR_i,
    output logic [RD_DATA_WIDTH-1:0] RDATA_o,
    output logic                     RVALID_o
);

    if ((WR_DATA_WIDTH != 9) && (WR_DATA_WIDTH != 18)) begin : gen_bad_wr_width
        $error("WR_DATA_WIDTH must be 9 or 18");
    end
    if ((RD_DATA_WIDTH != 9) && (RD_DATA_WIDTH != 18)) begin : gen_bad_rd_width
        $error("RD_DATA_WIDTH must be 9 or 18");
    end

    // Lanes split into even/odd banks so one pair address reaches both lanes of a word
    logic [LANE_W-1:0] mem_even [PAIRS];
    logic [LANE_W-1:0] mem_odd  [PAIRS];

    logic [PAIR_AW-1:0]       wr_pair;
    logic [1:0]               wr_mask;
    lane_pair_t               wr_lanes;
    logic [WR_DATA_WIDTH-1:0] wr_rdata_unused;

    logic [PAIR_AW-1:0]       rd_pair;
    logic [1:0]               rd_mask_unused;
    lane_pair_t               rd_lanes_unused;
    logic [RD_DATA_WIDTH-1:0] rd_word;

    logic [RD_DATA_WIDTH-1:0] rdata_q;
    logic                     rvalid_q;

    asym_bram_lane_mux #(
        .DATA_WIDTH(WR_DATA_WIDTH)
    ) u_wr_mux (
        .port_addr      (WR_ADDR_i),
        .port_wdata     (WDATA_i),
        .lane_rdata_even('0),
        .lane_rdata_odd ('0),
        .pair_addr      (wr_pair),
        .lane_mask      (wr_mask),
        .lane_wdata     (wr_lanes),
        .port_rdata     (wr_rdata_unused)
    );

    asym_bram_lane_mux #(
        .DATA_WIDTH(RD_DATA_WIDTH)
    ) u_rd_mux (
        .port_addr      (RD_ADDR_i),
        .port_wdata     ('0),
        .lane_rdata_even(mem_even[rd_pair]),
        .lane_rdata_odd (mem_odd[rd_pair]),
        .pair_addr      (rd_pair),
        .lane_mask      (rd_mask_unused),
        .lane_wdata     (rd_lanes_unused),
        .port_rdata     (rd_word)
    );

    // Array write; no reset on storage, writes are suppressed while reset is held
    always_ff @(posedge clock0) begin
        if (WEN_i && !RESET_i) begin
            if (wr_mask[0]) mem_even[wr_pair] <= wr_lanes.l0;
            if (wr_mask[1]) mem_odd[wr_pair]  <= wr_lanes.l1;
        end
    end

    // Read register samples pre-write array contents, giving read-first collisions
    always_ff @(posedge clock0 or posedge RESET_i) begin
        if (RESET_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= REN_i;
            if (REN_i) rdata_q <= rd_word;
        end
    end

    assign RDATA_o  = rdata_q;
    assign RVALID_o = rvalid_q;

endmodule

// File: tb/tb_asym_sdp_bram18k_core.sv
// Directed self-checking bench for asym_sdp_bram18k_core in all four width pairings.
module tb_asym_sdp_bram18k_core;

    logic clock0 = 1'b0;
    logic rst    = 1'b1;

    always #5 clock0 = ~clock0;

    // a: 9w/18r, b: 18w/9r, c: 18w/18r, d: 9w/9r
    logic        wen_a = 0, ren_a = 0, rv_a;
    logic [10:0] wa_a = '0;
    logic [8:0]  wd_a = '0;
    logic [9:0]  ra_a = '0;
    logic [17:0] rd_a;

    logic        wen_b = 0, ren_b = 0, rv_b;
    logic [9:0]  wa_b = '0;
    logic [17:0] wd_b = '0;
    logic [10:0] ra_b = '0;
    logic [8:0]  rd_b;

    logic        wen_c = 0, ren_c = 0, rv_c;
    logic [9:0]  wa_c = '0;
    logic [17:0] wd_c = '0;
    logic [9:0]  ra_c = '0;
    logic [17:0] rd_c;

    logic        wen_d = 0, ren_d = 0, rv_d;
    logic [10:0] wa_d = '0;
    logic [8:0]  wd_d = '0;
    logic [10:0] ra_d = '0;
    logic [8:0]  rd_d;

    int n_cmp = 0;
    int n_err = 0;

    asym_sdp_bram18k_core #(.WR_DATA_WIDTH(9), .RD_DATA_WIDTH(18)) dut_a (
        .clock0(clock0), .RESET_i(rst), .WEN_i(wen_a), .WR_ADDR_i(wa_a), .WDATA_i(wd_a),
        .REN_i(ren_a), .RD_ADDR_i(ra_a), .RDATA_o(rd_a), .RVALID_o(rv_a)
    );
    asym_sdp_bram18k_core #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(9)) dut_b (
        .clock0(clock0), .RESET_i(rst), .WEN_i(wen_b), .WR_ADDR_i(wa_b), .WDATA_i(wd_b),
        .REN_i(ren_b), .RD_ADDR_i(ra_b), .RDATA_o(rd_b), .RVALID_o(rv_b)
    );
    asym_sdp_bram18k_core #(.WR_DATA_WIDTH(18), .RD_DATA_WIDTH(18)) dut_c (
        .clock0(clock0), .RESET_i(rst), .WEN_i(wen_c), .WR_ADDR_i(wa_c), .WDATA_i(wd_c),
        .REN_i(ren_c), .RD_ADDR_i(ra_c), .RDATA_o(rd_c), .RVALID_o(rv_c)
    );
    asym_sdp_bram18k_core #(.WR_DATA_WIDTH(9), .RD_DATA_WIDTH(9)) dut_d (
        .clock0(clock0), .RESET_i(rst), .WEN_i(wen_d), .WR_ADDR_i(wa_d), .WDATA_i(wd_d),
        .REN_i(ren_d), .RD_ADDR_i(ra_d), .RDATA_o(rd_d), .RVALID_o(rv_d)
    );

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [17:0] m_c [1024];
    logic [8:0]  m_d [2048];
    logic [9:0]  addr_c [200];
    logic [10:0] addr_d [200];

    initial begin
        logic [10:0] av;
        logic [9:0]  wv;

        // Reset state
        #1;
        check("reset_rdata", rd_a, 18'h0);
        check("reset_rvalid", {17'h0, rv_a}, 18'h0);
        tick();
        rst = 1'b0;
        tick();

        // 1. 9w/18r fill lanes, read words
        for (int a = 0; a < 2048; a++) begin
            av = a[10:0];
            wen_a = 1; wa_a = av; wd_a = av[9:1];
            tick();
        end
        wen_a = 0;
        for (int w = 0; w < 1024; w++) begin
            wv = w[9:0];
            ren_a = 1; ra_a = wv;
            tick();
            check("t1_word", rd_a, {wv[8], wv[8], wv[7:0], wv[7:0]});
            check("t1_rvalid", {17'h0, rv_a}, 18'h1);
        end
        ren_a = 0;
        tick();
        check("idle_rvalid", {17'h0, rv_a}, 18'h0);

        // 3. Latency and hold
        ren_a = 1; ra_a = 10'd5;
        tick();
        ren_a = 0; ra_a = 10'd9;
        check("t3_rvalid_hi", {17'h0, rv_a}, 18'h1);
        check("t3_rdata", rd_a, 18'h00505);
        tick();
        check("t3_rvalid_lo", {17'h0, rv_a}, 18'h0);
        check("t3_hold1", rd_a, 18'h00505);
        tick();
        check("t3_hold2", rd_a, 18'h00505);

        // 4. Collision read-first
        wen_a = 1; wa_a = 11'd6; wd_a = 9'h1FF;
        tick();
        wa_a = 11'd7;
        tick();
        wa_a = 11'd6; wd_a = 9'h000;
        ren_a = 1; ra_a = 10'd3;
        tick();
        wen_a = 0;
        check("t4_collide", rd_a, 18'h3FFFF);
        tick();
        ren_a = 0;
        check("t4_after", rd_a, 18'h2FF00);

        // 5. Reset mid-read; write/read during reset ignored
        ren_a = 1; ra_a = 10'd10;
        tick();
        check("t5_inflight", {17'h0, rv_a}, 18'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_rdata", rd_a, 18'h0);
        check("t5_rst_rvalid", {17'h0, rv_a}, 18'h0);
        wen_a = 1; wa_a = 11'd20; wd_a = 9'h155;
        tick();
        check("t5_rst_ren_ignored", {17'h0, rv_a}, 18'h0);
        wen_a = 0; ren_a = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_rvalid", {17'h0, rv_a}, 18'h0);
        end
        ren_a = 1; ra_a = 10'd10;
        tick();
        check("t5_word10", rd_a, 18'h00A0A);
        ra_a = 10'h1FF;
        tick();
        ren_a = 0;
        check("t5_word1ff", rd_a, 18'h3FFFF);

        // 2. 18w/9r
        for (int w = 0; w < 1024; w++) begin
            wv = w[9:0];
            wen_b = 1; wa_b = wv; wd_b = {wv[8], wv[8], wv[7:0], wv[7:0]};
            tick();
        end
        wen_b = 0;
        for (int a = 0; a < 2048; a++) begin
            av = a[10:0];
            ren_b = 1; ra_b = av;
            tick();
            check("t2_lane", {9'h0, rd_b}, {9'h0, av[9:1]});
        end
        ren_b = 0;

        // 6. 18w/18r and 9w/9r random pairs
        for (int i = 0; i < 200; i++) begin
            addr_c[i] = 10'($urandom_range(0, 1023));
            addr_d[i] = 11'($urandom_range(0, 2047));
            wen_c = 1; wa_c = addr_c[i]; wd_c = 18'($urandom);
            wen_d = 1; wa_d = addr_d[i]; wd_d = 9'($urandom);
            m_c[addr_c[i]] = wd_c;
            m_d[addr_d[i]] = wd_d;
            tick();
        end
        wen_c = 0; wen_d = 0;
        for (int i = 0; i < 200; i++) begin
            ren_c = 1; ra_c = addr_c[i];
            ren_d = 1; ra_d = addr_d[i];
            tick();
            check("t6_18x18", rd_c, m_c[addr_c[i]]);
            check("t6_9x9", {9'h0, rd_d}, {9'h0, m_d[addr_d[i]]});
        end
        ren_c = 0; ren_d = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
